// File: rtl/mul_share_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mul_share_arbiter (with mul_karatsuba)
// Description : Round-robin sharing of one 16x16 Karatsuba multiplier between
//               NUM_REQ requesters through a two-stage stallable pipeline.
// Revision    : 1.0 - initial release
// ============================================================================

module mul_karatsuba (
    input  logic [15:0] i_a,
    input  logic [15:0] i_b,
    output logic [31:0] o_p
);

    logic [7:0]  a_hi;
    logic [7:0]  a_lo;
    logic [7:0]  b_hi;
    logic [7:0]  b_lo;
    logic [15:0] z2;
    logic [15:0] z0;
    logic [8:0]  a_sum;
    logic [8:0]  b_sum;
    logic [17:0] z_mid;
    logic [17:0] z1;

    assign a_hi  = i_a[15:8];
    assign a_lo  = i_a[7:0];
    assign b_hi  = i_b[15:8];
    assign b_lo  = i_b[7:0];

    assign z2    = {8'b0, a_hi} * {8'b0, b_hi};
    assign z0    = {8'b0, a_lo} * {8'b0, b_lo};
    assign a_sum = {1'b0, a_hi} + {1'b0, a_lo};
    assign b_sum = {1'b0, b_hi} + {1'b0, b_lo};
    assign z_mid = {9'b0, a_sum} * {9'b0, b_sum};

    // Cross term a_hi*b_lo + a_lo*b_hi never exceeds 17 bits, so 18 is safe.
    assign z1    = z_mid - {2'b0, z2} - {2'b0, z0};

    assign o_p   = {z2, 16'b0} + {6'b0, z1, 8'b0} + {16'b0, z0};

endmodule

module mul_share_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_REQ-1:0]   req_valid,
    output logic [NUM_REQ-1:0]   req_ready,
    input  logic [16*NUM_REQ-1:0] req_a,
    input  logic [16*NUM_REQ-1:0] req_b,
    output logic                 resp_valid,
    input  logic                 resp_ready,
    output logic [31:0]          resp_product,
    output logic [ID_W-1:0]      resp_id,
    output logic                 busy
);

    localparam logic [ID_W:0]   c_num_req = (ID_W+1)'(NUM_REQ);
    localparam logic [ID_W-1:0] c_last_id = ID_W'(NUM_REQ - 1);

    logic [ID_W-1:0] ptr_q;
    logic [ID_W-1:0] ptr_d;
    logic            s1_valid_q;
    logic            s1_valid_d;
    logic [15:0]     s1_a_q;
    logic [15:0]     s1_a_d;
    logic [15:0]     s1_b_q;
    logic [15:0]     s1_b_d;
    logic [ID_W-1:0] s1_id_q;
    logic [ID_W-1:0] s1_id_d;
    logic            resp_valid_q;
    logic            resp_valid_d;
    logic [31:0]     resp_product_q;
    logic [31:0]     resp_product_d;
    logic [ID_W-1:0] resp_id_q;
    logic [ID_W-1:0] resp_id_d;

    logic            s2_free;
    logic            s1_free;
    logic            s1_adv;
    logic            accept;
    logic            grant_found;
    logic [ID_W-1:0] grant_id;
    logic [ID_W:0]   cand;
    logic [15:0]     sel_a;
    logic [15:0]     sel_b;
    logic [31:0]     mul_p;

    assign s2_free = !resp_valid_q | resp_ready;
    assign s1_free = !s1_valid_q | s2_free;
    assign s1_adv  = s1_valid_q & s2_free;
    assign accept  = s1_free & grant_found;

    // Search ptr, ptr+1, ... with wrap; first valid requester wins.
    always_comb begin
        grant_found = 1'b0;
        grant_id    = '0;
        cand        = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = {1'b0, ptr_q} + (ID_W+1)'(k);
            if (cand >= c_num_req) begin
                cand = cand - c_num_req;
            end
            if (!grant_found && req_valid[cand[ID_W-1:0]]) begin
                grant_found = 1'b1;
                grant_id    = cand[ID_W-1:0];
            end
        end
    end

    always_comb begin
        sel_a = '0;
        sel_b = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_id == ID_W'(i)) begin
                sel_a = req_a[16*i +: 16];
                sel_b = req_b[16*i +: 16];
            end
        end
    end

    // Ready is forced low during reset since the cleared pipeline looks free.
    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_ready
            assign req_ready[gi] = !rst & accept & (grant_id == ID_W'(gi));
        end
    endgenerate

    mul_karatsuba u_mul (
        .i_a (s1_a_q),
        .i_b (s1_b_q),
        .o_p (mul_p)
    );

    always_comb begin
        ptr_d          = ptr_q;
        s1_valid_d     = s1_valid_q;
        s1_a_d         = s1_a_q;
        s1_b_d         = s1_b_q;
        s1_id_d        = s1_id_q;
        resp_valid_d   = resp_valid_q;
        resp_product_d = resp_product_q;
        resp_id_d      = resp_id_q;

        if (accept) begin
            s1_valid_d = 1'b1;
            s1_a_d     = sel_a;
            s1_b_d     = sel_b;
            s1_id_d    = grant_id;
            ptr_d      = (grant_id == c_last_id) ? '0 : grant_id + 1'b1;
        end else if (s1_adv) begin
            s1_valid_d = 1'b0;
        end

        if (s1_adv) begin
            resp_valid_d   = 1'b1;
            resp_product_d = mul_p;
            resp_id_d      = s1_id_q;
        end else if (resp_ready) begin
            resp_valid_d   = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q          <= '0;
            s1_valid_q     <= 1'b0;
            s1_a_q         <= '0;
            s1_b_q         <= '0;
            s1_id_q        <= '0;
            resp_valid_q   <= 1'b0;
            resp_product_q <= '0;
            resp_id_q      <= '0;
        end else begin
            ptr_q          <= ptr_d;
            s1_valid_q     <= s1_valid_d;
            s1_a_q         <= s1_a_d;
            s1_b_q         <= s1_b_d;
            s1_id_q        <= s1_id_d;
            resp_valid_q   <= resp_valid_d;
            resp_product_q <= resp_product_d;
            resp_id_q      <= resp_id_d;
        end
    end

    assign resp_valid   = resp_valid_q;
    assign resp_product = resp_product_q;
    assign resp_id      = resp_id_q;
    assign busy         = s1_valid_q | resp_valid_q;

endmodule

`default_nettype wire

// File: tb/tb_mul_share_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mul_share_arbiter
// Description : Directed self-checking bench for mul_share_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================

module tb_mul_share_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  req_valid = 4'hF;
    wire  [3:0]  req_ready;
    logic [63:0] req_a = '0;
    logic [63:0] req_b = '0;
    wire         resp_valid;
    logic        resp_ready = 1'b1;
    wire  [31:0] resp_product;
    wire  [1:0]  resp_id;
    wire         busy;

    int n_checks = 0;
    int n_fail   = 0;

    logic [15:0] tab_a [7] = '{16'hFFFF, 16'h0000, 16'h8000, 16'h00FF, 16'hABCD, 16'h1234, 16'hFF01};
    logic [15:0] tab_b [7] = '{16'hFFFF, 16'hFFFF, 16'h8000, 16'hFF00, 16'h0001, 16'h5678, 16'h01FF};
    logic [31:0] tab_p [7] = '{32'hFFFE0001, 32'h00000000, 32'h40000000, 32'h00FE0100,
                               32'h0000ABCD, 32'h06260060, 32'h01FD02FF};

    mul_share_arbiter #(.NUM_REQ(4), .ID_W(2)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_a        (req_a),
        .req_b        (req_b),
        .resp_valid   (resp_valid),
        .resp_ready   (resp_ready),
        .resp_product (resp_product),
        .resp_id      (resp_id),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input int i, input logic [15:0] a, input logic [15:0] b);
        req_a[16*i +: 16] = a;
        req_b[16*i +: 16] = b;
    endtask

    task automatic chk_resp(input string tag, input logic [31:0] p, input logic [1:0] id);
        chk({tag, "_valid"}, {31'b0, resp_valid}, 32'd1);
        chk({tag, "_prod"},  resp_product, p);
        chk({tag, "_id"},    {30'b0, resp_id}, {30'b0, id});
    endtask

    task automatic do_reset();
        rst        = 1'b1;
        req_valid  = '0;
        resp_ready = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state, with all requesters asserting valid while in reset
        @(negedge clk);
        chk("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
        chk("rst_busy",       {31'b0, busy}, 32'd0);
        chk("rst_req_ready",  {28'b0, req_ready}, 32'd0);
        chk("rst_product",    resp_product, 32'd0);
        chk("rst_id",         {30'b0, resp_id}, 32'd0);
        step();
        rst       = 1'b0;
        req_valid = '0;

        // Single request from requester 2
        set_op(2, 16'h1234, 16'h5678);
        req_valid = 4'b0100;
        @(negedge clk);
        chk("single_ready", {28'b0, req_ready}, 32'h4);
        step();
        req_valid = '0;
        @(negedge clk);
        chk("single_c1_valid", {31'b0, resp_valid}, 32'd0);
        chk("single_c1_busy",  {31'b0, busy}, 32'd1);
        step();
        @(negedge clk);
        chk_resp("single_c2", 32'h06260060, 2'd2);
        step();
        @(negedge clk);
        chk("single_c3_valid", {31'b0, resp_valid}, 32'd0);
        chk("single_c3_busy",  {31'b0, busy}, 32'd0);
        step();

        // All four requesters valid from cycle 0
        do_reset();
        for (int i = 0; i < 4; i++) set_op(i, 16'(i + 1), 16'h0100);
        req_valid = 4'hF;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            chk("all_ready", {28'b0, req_ready}, (c < 4) ? (32'd1 << c) : 32'd0);
            if (c >= 2) chk_resp("all_resp", 32'(c - 1) << 8, 2'(c - 2));
            else        chk("all_early_valid", {31'b0, resp_valid}, 32'd0);
            step();
            if (c < 4) req_valid[c] = 1'b0;
        end

        // Pointer wrap: ptr=0 after granting 3
        set_op(0, 16'd7, 16'd9);
        set_op(3, 16'd3, 16'h1000);
        req_valid = 4'b1001;
        @(negedge clk);
        chk("wrap_grant0", {28'b0, req_ready}, 32'h1);
        step();
        @(negedge clk);
        chk("wrap_ptr1_grant3", {28'b0, req_ready}, 32'h8);
        step();
        req_valid = '0;
        @(negedge clk);
        chk_resp("wrap_r0", 32'd63, 2'd0);
        step();
        @(negedge clk);
        chk_resp("wrap_r3", 32'h3000, 2'd3);
        step();
        @(negedge clk);
        chk("wrap_idle", {31'b0, resp_valid}, 32'd0);
        step();

        // Backpressure: two in flight, then resp_ready low for 3 cycles
        set_op(1, 16'h0011, 16'h0011);
        req_valid = 4'b0010;
        @(negedge clk);
        chk("bp_ready1", {28'b0, req_ready}, 32'h2);
        step();
        set_op(2, 16'h0100, 16'h0100);
        req_valid = 4'b0100;
        @(negedge clk);
        chk("bp_ready2", {28'b0, req_ready}, 32'h4);
        step();
        resp_ready = 1'b0;
        set_op(3, 16'd5, 16'd5);
        req_valid = 4'b1000;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk_resp("bp_hold", 32'h121, 2'd1);
            chk("bp_ready_blocked", {28'b0, req_ready}, 32'h0);
            chk("bp_busy", {31'b0, busy}, 32'd1);
            step();
        end
        resp_ready = 1'b1;
        @(negedge clk);
        chk_resp("bp_release", 32'h121, 2'd1);
        chk("bp_ready3", {28'b0, req_ready}, 32'h8);
        step();
        req_valid = '0;
        @(negedge clk);
        chk_resp("bp_second", 32'h10000, 2'd2);
        step();
        @(negedge clk);
        chk_resp("bp_third", 32'd25, 2'd3);
        step();
        @(negedge clk);
        chk("bp_idle", {31'b0, resp_valid}, 32'd0);
        step();

        // Operand table streamed back-to-back through requester 2
        for (int c = 0; c < 9; c++) begin
            if (c < 7) begin
                set_op(2, tab_a[c], tab_b[c]);
                req_valid = 4'b0100;
            end else begin
                req_valid = '0;
            end
            @(negedge clk);
            if (c < 7)  chk("op_ready", {28'b0, req_ready}, 32'h4);
            if (c >= 2) chk_resp("op_prod", tab_p[c - 2], 2'd2);
            step();
        end
        @(negedge clk);
        chk("op_drained", {31'b0, busy}, 32'd0);
        step();

        // Reset mid-operation with S1 and S2 full
        resp_ready = 1'b0;
        set_op(1, 16'd2, 16'd3);
        req_valid = 4'b0010;
        @(negedge clk);
        chk("mr_ready1", {28'b0, req_ready}, 32'h2);
        step();
        set_op(2, 16'd4, 16'd4);
        req_valid = 4'b0100;
        @(negedge clk);
        chk("mr_ready2", {28'b0, req_ready}, 32'h4);
        step();
        set_op(0, 16'h000A, 16'h000B);
        set_op(3, 16'h000C, 16'h000D);
        req_valid = 4'b1001;
        @(negedge clk);
        chk("mr_full_valid", {31'b0, resp_valid}, 32'd1);
        chk("mr_full_busy",  {31'b0, busy}, 32'd1);
        chk("mr_full_ready", {28'b0, req_ready}, 32'h0);
        #2;
        rst = 1'b1;
        #1;
        chk("mr_async_valid", {31'b0, resp_valid}, 32'd0);
        chk("mr_async_busy",  {31'b0, busy}, 32'd0);
        chk("mr_async_ready", {28'b0, req_ready}, 32'h0);
        chk("mr_async_prod",  resp_product, 32'd0);
        step();
        chk("mr_in_rst_ready", {28'b0, req_ready}, 32'h0);
        rst        = 1'b0;
        resp_ready = 1'b1;
        @(negedge clk);
        chk("mr_first_grant", {28'b0, req_ready}, 32'h1);
        chk("mr_no_stale0", {31'b0, resp_valid}, 32'd0);
        step();
        req_valid = 4'b1000;
        @(negedge clk);
        chk("mr_second_grant", {28'b0, req_ready}, 32'h8);
        chk("mr_no_stale1", {31'b0, resp_valid}, 32'd0);
        step();
        req_valid = '0;
        @(negedge clk);
        chk_resp("mr_r0", 32'd110, 2'd0);
        step();
        @(negedge clk);
        chk_resp("mr_r3", 32'd156, 2'd3);
        step();
        @(negedge clk);
        chk("mr_idle", {31'b0, busy}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/mul_share_arbiter.md
Name: mul_share_arbiter

Overview:
- Shares one 16x16 Karatsuba multiplier instance (mul_karatsuba) between NUM_REQ independent requesters.
- Arbitration is round-robin.
- Accepted operand pairs pass through a 2-stage pipeline: an operand register, then the multiplier, then a result register.
- Each result returns on a single response channel tagged with the requester index. The block sits between the compute clients and the shared multiplier datapath.

Parameters:
- NUM_REQ, 4, number of requesters (2..16).
- ID_W, 2, requester-index width. Must equal max(1, ceil(log2(NUM_REQ))).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- req_valid  input  NUM_REQ  per-requester operand valid.
- req_ready  output  NUM_REQ  per-requester accept strobe.
- req_a  input  16*NUM_REQ  operand A; requester i at bits [16*i+15:16*i].
- req_b  input  16*NUM_REQ  operand B; same packing as req_a.
- resp_valid  output  1  result valid.
- resp_ready  input  1  consumer ready.
- resp_product  output  32  a*b of the accepted request.
- resp_id  output  ID_W  index of the requester that issued it.
- busy  output  1  high when any operation is in flight (s1_valid | resp_valid).

Behaviour:
- Reset (async, immediate):
  - s1_valid=0, resp_valid=0, resp_product=0, resp_id=0.
  - Round-robin pointer ptr=0; busy=0; req_ready=0.
  - All in-flight operations are discarded; no response is produced for them after reset release.
- Stage S1 register holds s1_a, s1_b, s1_id, s1_valid. It feeds mul_karatsuba combinationally.
- Stage S2 is the output register: resp_product, resp_id, resp_valid.
- Stall chain, combinational:
  - s2_free = !resp_valid | resp_ready.
  - s1_free = !s1_valid | s2_free.
- Arbitration, combinational:
  - Grant g = first index with req_valid set, searching ptr, ptr+1, ... NUM_REQ-1, 0, ... (wraps).
  - req_ready[g] = s1_free & any(req_valid). All other req_ready bits are 0.
  - req_ready depends on req_valid. Requesters must not derive req_valid from req_ready.
- Transfer: a request transfers when req_valid[i] & req_ready[i]. On that edge:
  - S1 loads req_a/req_b slice i and id=i; s1_valid=1.
  - ptr <= (i+1) mod NUM_REQ.
  - ptr is unchanged when there is no transfer.
- S1 to S2: when s1_valid & s2_free, S2 loads the product and s1_id; resp_valid=1.
  - If no new transfer occurs on that same edge, s1_valid <= 0.
- Response handshake: resp_valid & resp_ready completes the response.
  - If S1 does not advance on that edge, resp_valid <= 0.
  - While resp_valid=1 & resp_ready=0, resp_product and resp_id hold stable.
- Latency: exactly 2 cycles from accept edge to resp_valid high, absent backpressure.
- Throughput: 1 result/cycle with resp_ready held high. Simultaneous S2 drain, S1 advance and new accept on the same edge is required.
- Backpressure:
  - With S2 full and stalled, S1 holds.
  - With S1 also full, all req_ready=0.
  - At most 2 operations are in flight.
- Arithmetic: product is the full 32-bit unsigned result, no truncation. 0xFFFF*0xFFFF = 0xFFFE0001.
- A requester that drops req_valid without being accepted loses nothing; no state is recorded for it.
- Ordering: responses leave in accept order.

Test Plan:
- Single request: rst released, requester 2 drives a=0x1234, b=0x5678 at cycle 0, resp_ready=1 -> req_ready[2]=1 at cycle 0; resp_valid=1 at cycle 2 with product 0x06260060, id=2; busy then falls.
- All 4 requesters valid from cycle 0 with a=i+1, b=0x0100, resp_ready=1 -> grants 0,1,2,3 on consecutive cycles; responses 0x0100, 0x0200, 0x0300, 0x0400 with ids 0,1,2,3 on cycles 2..5; no bubbles.
- Pointer wrap: after granting requester 3, requesters 0 and 3 both valid -> requester 0 granted first; ptr=1 afterwards.
- Backpressure: two requests accepted, then resp_ready=0 for 3 cycles -> resp holds the first result stable; all req_ready=0 once S1 is full. On resp_ready=1, the second result follows the very next cycle.
- Max operands: a=b=0xFFFF -> product 0xFFFE0001. Also a=0, b=0xFFFF -> product 0.
- Reset mid-operation: assert rst asynchronously (mid-cycle) with S1 and S2 both full -> resp_valid, busy and req_ready fall immediately. After release, no stale response appears and the first grant goes to requester 0.
